icache_loader: RTL
==================

Name: icache_loader

Overview:
- Writer-side initiator for the instruction cache's read/write port (port A).
- Accepts a valid/ready stream of instruction words from the host/program loader and writes them to consecutive cache addresses starting at a given base.
- Then reads the written range back through the same port and checks it against a running checksum.
- Sits between the host load path and the I-cache. The fetch side (port B) is untouched.

Parameters:
DATA  32  instruction word width; must match the cache DATA
ADDR  10  cache address width; the cache holds 2**ADDR words

Ports:
clk        input   1       single clock; drives this block and cache port A
rst        input   1       synchronous, active-high reset
start      input   1       one-cycle request to begin a load; honoured only in IDLE
base_addr  input   ADDR    first cache address to write; sampled with start
length     input   ADDR+1  number of words to load, 0..2**ADDR; sampled with start
s_valid    input   1       stream word valid
s_data     input   DATA    stream word
s_ready    output  1       block accepts s_data this cycle
a_wr       output  1       cache port A write enable
a_addr     output  ADDR    cache port A address
a_din      output  DATA    cache port A write data
a_dout     input   DATA    cache port A read data; 2-cycle read latency
busy       output  1       high in every state except IDLE
done       output  1       one-cycle pulse when a load finishes
error      output  1       sticky readback-checksum mismatch; cleared by the next accepted start or by rst

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE.
  - s_ready, a_wr, done, error, busy = 0; a_addr, a_din = 0.
  - Counters and checksums cleared.
  - rst at any point, including mid-LOAD or mid-VERIFY, aborts the operation with no done pulse. Words already written stay in the cache.
- Registered outputs: a_wr, a_addr, a_din, s_ready, done, error. busy is decoded from state.
- IDLE:
  - s_ready=0; a_wr=0.
  - On start=1:
    - Latch base_addr and length.
    - Clear wr_cnt, rd_cnt, wsum, rsum, error.
    - If length=0, go to DONE. Otherwise go to LOAD.
  - start is ignored in every other state.
- LOAD:
  - s_ready=1 while wr_cnt < length.
  - A handshake is s_valid & s_ready at a clk edge. On each handshake:
    - The next cycle drives a_wr=1, a_addr=(base+wr_cnt) mod 2**ADDR, a_din=s_data.
    - wsum += s_data (mod 2**DATA); wr_cnt++.
  - Cycles with no handshake drive a_wr=0.
  - s_ready drops to 0 in the cycle after the final handshake (no over-accept).
  - When the last write has been issued, go to VERIFY.
- VERIFY:
  - a_wr=0. One read address per cycle: a_addr=(base+rd_cnt) mod 2**ADDR; rd_cnt++ until rd_cnt=length.
  - A 2-stage valid shift register tracks outstanding reads. Data for the address presented in cycle t is on a_dout in cycle t+2; rsum += a_dout (mod 2**DATA) in that cycle.
  - After the last read data is summed (2 cycles after the last address), go to DONE.
- DONE:
  - One cycle: done=1, error=(rsum != wsum), then return to IDLE.
  - For length=0 both sums are 0, so done pulses 2 cycles after start with error=0.
- Address arithmetic wraps modulo 2**ADDR. length=2**ADDR covers the whole cache exactly once.
- s_valid outside LOAD is ignored; s_ready is 0 there.
- Minimum latency for length N with s_valid held high:
  - start at cycle 0; first handshake in cycle 1.
  - Last write issued in cycle N+1; reads in cycles N+2..2N+1.
  - Last data summed in cycle 2N+3; done pulses in cycle 2N+4.

Test Plan:
- Basic load: base=0x010, length=4, words 0x11111111/0x22222222/0x33333333/0x44444444 with s_valid held high -> writes to 0x010..0x013 in order, reads back the same four words, done pulses at cycle 12, error=0, busy low after done.
- Zero length: start with length=0 -> no a_wr, s_ready stays 0, done pulses 2 cycles after start, error=0.
- Wrap-around: base=0x3FE, length=4 -> write addresses 0x3FE, 0x3FF, 0x000, 0x001; readback matches; error=0.
- Backpressure/gaps: s_valid toggled 1,0,0,1,... over 3 words -> exactly 3 a_wr pulses, each one cycle after its handshake; s_ready=0 after the 3rd handshake; error=0.
- Mismatch: bench cache model flips bit 0 of the word returned for address 0x012 during VERIFY -> done with error=1; error holds until the next start, which clears it.
- Reset and busy: rst during LOAD after 2 of 8 words -> next cycle IDLE, all outputs 0, no done pulse. A start pulsed while busy=1 on a fresh load is ignored: base and length remain from the original start.

Source files
------------

// File: rtl/icache_loader.sv
// icache_loader: streams instruction words into I-cache port A starting at a
// base address, then reads the same range back and compares a running sum of
// the read data against the sum of the written data.
module icache_loader #(
    parameter int DATA = 32,
    parameter int ADDR = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ADDR-1:0] base_addr,
    input  logic [ADDR:0]   length,
    input  logic            s_valid,
    input  logic [DATA-1:0] s_data,
    output logic            s_ready,
    output logic            a_wr,
    output logic [ADDR-1:0] a_addr,
    output logic [DATA-1:0] a_din,
    input  logic [DATA-1:0] a_dout,
    output logic            busy,
    output logic            done,
    output logic            error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [ADDR-1:0] base_r;
    logic [ADDR:0]   len_r;
    logic [ADDR:0]   wr_cnt;
    logic [ADDR:0]   rd_cnt;
    logic [DATA-1:0] wsum;
    logic [DATA-1:0] rsum;
    logic [DATA-1:0] rsum_nxt;

    // vld_p0 accompanies the read address on a_addr; vld_p1/vld_p2 follow the
    // request through the cache's two-cycle read latency.
    logic            vld_p0;
    logic            vld_p1;
    logic            vld_p2;

    logic            accept;
    logic            hs;
    logic            load_last;
    logic            rd_go;
    logic            rd_last;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (length == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (load_last) begin
                    state_nxt = VERIFY;
                end
            end
            VERIFY: begin
                if (rd_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output and control decode; the final read is the one whose data is one
    // cycle from arriving once no further address is being presented.
    always_comb begin
        busy      = (state != IDLE);
        accept    = (state == IDLE) && start;
        hs        = (state == LOAD) && s_valid && s_ready;
        load_last = hs && ((wr_cnt + (ADDR+1)'(1)) == len_r);
        rd_go     = (state == VERIFY) && (rd_cnt != len_r);
        rd_last   = (state == VERIFY) && (rd_cnt == len_r) && !vld_p0 && vld_p1;
        rsum_nxt  = vld_p2 ? (rsum + a_dout) : rsum;
    end

    // Registered port-A drive, stream handshake, counters and checksums.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_r  <= '0;
            len_r   <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            wsum    <= '0;
            rsum    <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            s_ready <= 1'b0;
            a_wr    <= 1'b0;
            a_addr  <= '0;
            a_din   <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            a_wr   <= hs;
            done   <= (state == DONE);
            vld_p0 <= rd_go;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            rsum   <= accept ? '0 : rsum_nxt;

            if (accept) begin
                base_r  <= base_addr;
                len_r   <= length;
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                wsum    <= '0;
                error   <= 1'b0;
                s_ready <= (length != '0);
            end

            if (hs) begin
                a_addr <= base_r + wr_cnt[ADDR-1:0];
                a_din  <= s_data;
                wsum   <= wsum + s_data;
                wr_cnt <= wr_cnt + (ADDR+1)'(1);
            end

            if (load_last) begin
                s_ready <= 1'b0;
            end

            if (rd_go) begin
                a_addr <= base_r + rd_cnt[ADDR-1:0];
                rd_cnt <= rd_cnt + (ADDR+1)'(1);
            end

            if (state == DONE) begin
                error <= (rsum_nxt != wsum);
            end
        end
    end

endmodule
